note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Producer side of the note-timer interface: walks a song stored in a synchronous ROM one note at a time.
- For each note it loads the duration into the note timer (`update_note_length`/`note_length`), gates the timer with `play`/`pause`, and advances when it sees `note_did_end`.
- Drives the current note code to the synthesis path and flags end of song.
- Sits between the user controls / beat generator and the `note_timer` + ROM.

Parameters:
- SONG_W, 2, song-select width; ROM holds 2^SONG_W songs.
- IDX_W, 5, note-index width; at most 2^IDX_W notes per song.
- NOTE_W, 6, note-code width; code 0 = rest.
- DUR_W, 6, duration width; must match the timer's `note_length` width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play_pause  in  1  single-cycle pulse; toggles run/pause, or starts a song from IDLE
- stop  in  1  single-cycle pulse; abort to IDLE
- song  in  SONG_W  song select, sampled only on start
- beat  in  1  single-cycle beat tick that decrements the timer
- rom_addr  out  SONG_W+IDX_W  {song_q, idx}
- rom_data  in  NOTE_W+DUR_W  {note code [11:6], duration [5:0]}; valid 1 cycle after `rom_addr`
- update_note_length  out  1  pulse: timer loads `note_length`
- note_length  out  DUR_W  duration to load
- play  out  1  timer decrement enable = `beat` & running
- pause  out  1  high in PLAYING while paused
- note_did_end  in  1  pulse from the timer
- note  out  NOTE_W  current note code; 0 when not playing
- new_note  out  1  pulse when `note` changes to a fetched note
- song_done  out  1  pulse at end of song
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async): state=IDLE, idx=0, song_q=0, paused=0.
  - All outputs 0, except `rom_addr`=0.
- States: IDLE, FETCH, WAIT, LOAD, PLAYING, DONE.
- IDLE:
  - `play_pause` → song_q<=`song`, idx<=0, paused<=0, go to FETCH.
  - `note_did_end` is ignored; the timer pulses it after its own reset.
- FETCH: drive `rom_addr`={song_q, idx} (held stable in every state) → WAIT.
- WAIT: ROM latency cycle → LOAD.
- LOAD: sample `rom_data`.
  - Duration==0 is the end-of-song marker → DONE.
  - Otherwise, in the same cycle:
    - `update_note_length`=1 and `note_length`=duration.
    - Register `note`<=code and pulse `new_note`.
    - Go to PLAYING.
- PLAYING:
  - `play`=`beat` & ~paused; `pause`=paused.
  - `note_did_end`:
    - If idx==2^IDX_W-1 → DONE, with no wrap.
    - Else idx<=idx+1 → FETCH.
  - `note` holds through the fetch of the next note and changes only in LOAD, so there is no rest gap.
- DONE: `note`<=0, `song_done`=1 for exactly 1 cycle → IDLE.
- `play_pause` in FETCH/WAIT/LOAD/PLAYING toggles paused.
  - While paused, `play`=0, so the timer holds and no end arrives.
  - A fetch already in flight still completes LOAD, and the new note loads paused.
- `play_pause` together with `note_did_end` in PLAYING: the advance happens and paused toggles; both take effect.
- `stop` in any non-IDLE state:
  - Next state IDLE, `note`<=0, paused<=0, no `song_done`.
  - `stop` has priority over `play_pause`, `note_did_end` and the LOAD actions; no `update_note_length` in that cycle.
- `note_did_end` outside PLAYING is ignored.
- `update_note_length`, `new_note` and `song_done` never assert for more than 1 consecutive cycle.
- `song` changes after start have no effect until the next start.
- Latency:
  - `play_pause` in IDLE at cycle t: `update_note_length` at t+3.
  - `note_did_end` at cycle t: next `update_note_length` at t+3.
- Async reset mid-song: outputs clear immediately with no glitch pulses afterwards; the sequencer restarts only on `play_pause`.

Test Plan:
- Basic song: ROM song 1 = {(5,3),(9,2),(0,0)}; `play_pause` with `song`=1 → `rom_addr`=0x20, then `update_note_length` with `note_length`=3, `note`=5; after end, `note_length`=2, `note`=9; then `song_done` pulse, `note`=0, IDLE.
- Pause: mid-note, assert `play_pause` → `play` stays 0 despite `beat`s and `pause`=1, no advance; a second `play_pause` → `play` follows `beat` again and the note completes.
- Full-length song with no marker: 32 notes of duration 1 → idx reaches 31, then `song_done` after the 32nd `note_did_end`; idx never wraps to 0.
- Stop during WAIT → IDLE next cycle, no `update_note_length`, no `song_done`, `note`=0; stray `note_did_end` in IDLE → no effect.
- Simultaneous events: `play_pause` and `note_did_end` in the same PLAYING cycle → idx increments, next note loaded with `pause`=1. `stop` with `note_did_end` → IDLE.
- Async reset asserted mid-PLAYING between clock edges → `busy`/`note`/`play` 0 immediately; after release, `play_pause` restarts at idx 0.

Source files
------------

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - controls, song ROM and note-timer signals of the note sequencer
interface note_sequencer_if #(
    parameter int SONG_W = 2,
    parameter int IDX_W  = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
);
    logic                      play_pause;
    logic                      stop;
    logic [SONG_W-1:0]         song;
    logic                      beat;
    logic [SONG_W+IDX_W-1:0]   rom_addr;
    logic [NOTE_W+DUR_W-1:0]   rom_data;
    logic                      update_note_length;
    logic [DUR_W-1:0]          note_length;
    logic                      play;
    logic                      pause;
    logic                      note_did_end;
    logic [NOTE_W-1:0]         note;
    logic                      new_note;
    logic                      song_done;
    logic                      busy;

    modport master (
        input  play_pause, stop, song, beat, rom_data, note_did_end,
        output rom_addr, update_note_length, note_length, play, pause,
               note, new_note, song_done, busy
    );

    modport slave (
        output play_pause, stop, song, beat, rom_data, note_did_end,
        input  rom_addr, update_note_length, note_length, play, pause,
               note, new_note, song_done, busy
    );
endinterface

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - walks a song in a synchronous ROM and feeds each note to the note timer
module note_sequencer #(
    parameter int SONG_W = 2,
    parameter int IDX_W  = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic clk,
    input  logic reset,
    note_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_PLAYING,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [SONG_W-1:0]   song_q;
    logic [IDX_W-1:0]    idx_q;
    logic                paused_q;
    logic [NOTE_W-1:0]   note_q;
    logic                new_note_q;

    logic [DUR_W-1:0]    rom_dur;
    logic [NOTE_W-1:0]   rom_code;
    logic                load_ok;
    logic                in_song;

    assign rom_dur  = bus.rom_data[DUR_W-1:0];
    assign rom_code = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
    // stop wins over the LOAD actions, so the timer never sees a load on an abort cycle
    assign load_ok  = (state_q == S_LOAD) && (rom_dur != '0) && !bus.stop;
    assign in_song  = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                      (state_q == S_LOAD)  || (state_q == S_PLAYING);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            song_q     <= '0;
            idx_q      <= '0;
            paused_q   <= 1'b0;
            note_q     <= '0;
            new_note_q <= 1'b0;
        end else begin
            new_note_q <= 1'b0;
            if (state_q != S_IDLE && bus.stop) begin
                state_q  <= S_IDLE;
                note_q   <= '0;
                paused_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.play_pause) begin
                            song_q   <= bus.song;
                            idx_q    <= '0;
                            paused_q <= 1'b0;
                            state_q  <= S_FETCH;
                        end
                    end
                    S_FETCH: state_q <= S_WAIT;
                    S_WAIT:  state_q <= S_LOAD;
                    S_LOAD: begin
                        if (rom_dur == '0) begin
                            note_q  <= '0;
                            state_q <= S_DONE;
                        end else begin
                            note_q     <= rom_code;
                            new_note_q <= 1'b1;
                            state_q    <= S_PLAYING;
                        end
                    end
                    S_PLAYING: begin
                        // note_q is kept through the next fetch so there is no rest gap
                        if (bus.note_did_end) begin
                            if (&idx_q) begin
                                note_q  <= '0;
                                state_q <= S_DONE;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= S_FETCH;
                            end
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
                if (in_song && bus.play_pause) begin
                    paused_q <= ~paused_q;
                end
            end
        end
    end

    assign bus.rom_addr           = {song_q, idx_q};
    assign bus.update_note_length = load_ok;
    assign bus.note_length        = load_ok ? rom_dur : '0;
    assign bus.play               = (state_q == S_PLAYING) && bus.beat && !paused_q;
    assign bus.pause              = (state_q == S_PLAYING) && paused_q;
    assign bus.note               = note_q;
    assign bus.new_note           = new_note_q;
    assign bus.song_done          = (state_q == S_DONE) && !bus.stop;
    assign bus.busy               = (state_q != S_IDLE);
endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - randomized and directed bench for note_sequencer against a behavioural model
module tb_note_sequencer;
    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    note_sequencer_if #(.SONG_W(SONG_W), .IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

    note_sequencer #(.SONG_W(SONG_W), .IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [11:0] rom [0:127];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Model: song position, pause flag, and a countdown to the cycle the ROM word is consumed
    logic       m_active, m_paused, m_playing, m_newnote, m_done;
    logic [1:0] m_song;
    logic [4:0] m_idx;
    logic [5:0] m_note;
    int         m_ld;

    always @(posedge clk or posedge reset) begin : model
        logic [11:0] w;
        logic nn, dn;
        w  = rom[{m_song, m_idx}];
        nn = 1'b0;
        dn = 1'b0;
        if (reset) begin
            m_active = 0; m_paused = 0; m_playing = 0;
            m_song = 0; m_idx = 0; m_note = 0; m_ld = -1;
        end else if (!m_active) begin
            if (bus.play_pause) begin
                m_active = 1; m_song = bus.song; m_idx = 0; m_paused = 0; m_ld = 2;
            end
        end else if (bus.stop) begin
            m_active = 0; m_note = 0; m_paused = 0; m_playing = 0; m_ld = -1;
        end else if (m_done) begin
            m_active = 0;
        end else begin
            if (bus.play_pause) m_paused = ~m_paused;
            if (m_ld > 0) begin
                m_ld--;
            end else if (m_ld == 0) begin
                m_ld = -1;
                if (w[5:0] == 6'd0) begin
                    m_note = 0; dn = 1;
                end else begin
                    m_note = w[11:6]; nn = 1; m_playing = 1;
                end
            end else if (m_playing && bus.note_did_end) begin
                m_playing = 0;
                if (m_idx == 5'd31) begin
                    m_note = 0; dn = 1;
                end else begin
                    m_idx = m_idx + 5'd1; m_ld = 2;
                end
            end
        end
        m_newnote = nn;
        m_done    = dn;
    end

    task automatic check_outputs();
        logic [11:0] w;
        logic up;
        w  = rom[{m_song, m_idx}];
        up = m_active && (m_ld == 0) && (w[5:0] != 6'd0) && !bus.stop;
        chk("busy",        32'(bus.busy),               32'(m_active));
        chk("rom_addr",    32'(bus.rom_addr),           32'({m_song, m_idx}));
        chk("update",      32'(bus.update_note_length), 32'(up));
        chk("note_length", 32'(bus.note_length),        up ? 32'(w[5:0]) : 32'd0);
        chk("play",        32'(bus.play),               32'(m_playing & bus.beat & ~m_paused));
        chk("pause",       32'(bus.pause),              32'(m_playing & m_paused));
        chk("note",        32'(bus.note),               32'(m_note));
        chk("new_note",    32'(bus.new_note),           32'(m_newnote));
        chk("song_done",   32'(bus.song_done),          32'(m_done & ~bus.stop));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #4;
            check_outputs();
        end
    end

    task automatic set_in(input logic pp, input logic st, input logic nde, input logic bt);
        bus.play_pause = pp; bus.stop = st; bus.note_did_end = nde; bus.beat = bt;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        bus.play_pause = 0; bus.stop = 0; bus.note_did_end = 0; bus.beat = 0;
        #1;
    endtask

    task automatic start(input logic [1:0] s);
        bus.song = s;
        set_in(1, 0, 0, 0);
        adv();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            rom[i][11:6] = 6'($urandom_range(1, 63));
            rom[i][5:0]  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        end
        rom[32] = {6'd5, 6'd3};
        rom[33] = {6'd9, 6'd2};
        rom[34] = 12'd0;
        for (int k = 0; k < 32; k++) rom[64 + k] = {6'(k + 1), 6'd1};
        bus.rom_data = 0;
        bus.song = 0;
        bus.play_pause = 0; bus.stop = 0; bus.note_did_end = 0; bus.beat = 0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_note", 32'(bus.note), 32'd0);
        #1 reset = 0;
        @(posedge clk);
        #2;

        // basic song 1: (5,3),(9,2),end
        start(2'd1);
        chk("basic_addr", 32'(bus.rom_addr), 32'h20);
        adv(); adv();
        chk("basic_upd1", 32'(bus.update_note_length), 32'd1);
        chk("basic_len1", 32'(bus.note_length), 32'd3);
        adv();
        chk("basic_note1", 32'(bus.note), 32'd5);
        chk("basic_new1", 32'(bus.new_note), 32'd1);
        for (int b = 0; b < 2; b++) begin
            set_in(0, 0, 0, 1);
            chk("basic_play", 32'(bus.play), 32'd1);
            adv();
        end
        set_in(0, 0, 1, 0);
        adv();
        chk("basic_hold", 32'(bus.note), 32'd5);
        adv(); adv();
        chk("basic_upd2", 32'(bus.update_note_length), 32'd1);
        chk("basic_len2", 32'(bus.note_length), 32'd2);
        adv();
        chk("basic_note2", 32'(bus.note), 32'd9);
        set_in(0, 0, 1, 0);
        adv(); adv(); adv();
        chk("basic_marker_upd", 32'(bus.update_note_length), 32'd0);
        adv();
        chk("basic_done", 32'(bus.song_done), 32'd1);
        chk("basic_done_note", 32'(bus.note), 32'd0);
        adv();
        chk("basic_idle", 32'(bus.busy), 32'd0);

        // pause mid-note
        start(2'd1);
        adv(); adv(); adv();
        set_in(1, 0, 0, 0);
        adv();
        set_in(0, 0, 0, 1);
        chk("pause_play", 32'(bus.play), 32'd0);
        chk("pause_flag", 32'(bus.pause), 32'd1);
        adv();
        set_in(0, 0, 0, 1);
        adv();
        chk("pause_note", 32'(bus.note), 32'd5);
        chk("pause_addr", 32'(bus.rom_addr), 32'h20);
        set_in(1, 0, 0, 0);
        adv();
        set_in(0, 0, 0, 1);
        chk("resume_play", 32'(bus.play), 32'd1);
        chk("resume_pause", 32'(bus.pause), 32'd0);
        adv();
        set_in(0, 1, 0, 0);
        adv();
        chk("pause_stop", 32'(bus.busy), 32'd0);

        // full-length song 2: 32 notes of duration 1, no marker
        start(2'd2);
        adv(); adv();
        for (int k = 0; k < 32; k++) begin
            chk("full_len", 32'(bus.note_length), 32'd1);
            adv();
            chk("full_addr", 32'(bus.rom_addr), 32'({2'd2, 5'(k)}));
            set_in(0, 0, 1, 0);
            adv();
            if (k < 31) begin
                adv(); adv();
            end
        end
        chk("full_done", 32'(bus.song_done), 32'd1);
        chk("full_nowrap", 32'(bus.rom_addr), 32'h5F);
        adv();
        chk("full_idle", 32'(bus.busy), 32'd0);

        // stop during WAIT, then a stray note_did_end
        start(2'd1);
        adv();
        set_in(0, 1, 0, 0);
        chk("stopw_upd", 32'(bus.update_note_length), 32'd0);
        adv();
        chk("stopw_busy", 32'(bus.busy), 32'd0);
        chk("stopw_note", 32'(bus.note), 32'd0);
        set_in(0, 0, 1, 0);
        adv();
        chk("stray_busy", 32'(bus.busy), 32'd0);
        adv();

        // play_pause with note_did_end, then stop with note_did_end
        start(2'd1);
        adv(); adv(); adv();
        set_in(1, 0, 1, 0);
        adv(); adv(); adv();
        chk("sim_upd", 32'(bus.update_note_length), 32'd1);
        chk("sim_len", 32'(bus.note_length), 32'd2);
        adv();
        chk("sim_pause", 32'(bus.pause), 32'd1);
        chk("sim_note", 32'(bus.note), 32'd9);
        set_in(0, 1, 1, 0);
        adv();
        chk("sim_stop", 32'(bus.busy), 32'd0);

        // async reset mid-PLAYING
        start(2'd1);
        adv(); adv(); adv();
        set_in(0, 0, 0, 1);
        chk("ar_play_pre", 32'(bus.play), 32'd1);
        reset = 1;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_note", 32'(bus.note), 32'd0);
        chk("ar_play", 32'(bus.play), 32'd0);
        adv();
        reset = 0;
        adv();
        chk("ar_stays_idle", 32'(bus.busy), 32'd0);
        start(2'd3);
        chk("ar_restart", 32'(bus.rom_addr), 32'h60);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.song = 2'($urandom_range(0, 3));
            set_in($urandom_range(0, 15) == 0, $urandom_range(0, 59) == 0,
                   $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 499) == 0) begin
                reset = 1;
                #2;
                reset = 0;
            end
            adv();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
